// File: rtl/ntt_stage_sched_if.sv
// ntt_stage_sched_if
//   Bundles every control/status signal between the NTT stage sequencer and
//   the surrounding datapath (load source, coefficient RAM, butterfly units,
//   twiddle ROM, unload sink).
//   master : the environment side (drives start/mode/in_valid).
//   slave  : the sequencer side (drives addresses, strobes and flags).
//   Signals:
//     start, mode, in_valid          request / mode / load beat valid
//     in_ready, ld_we, ld_addr       load handshake and RAM write
//     bf_rd_en, bf_a0..3, tw_idx0/1  butterfly issue, addresses, twiddles
//     bf_mode                        latched transform direction
//     bf_wr_en, wb_a0..3             delayed write-back strobe / addresses
//     out_rd_en, out_idx, out_valid  unload read strobe, beat, data valid
//     in_done, cal_done, done        phase-complete flags
interface ntt_stage_sched_if #(
    parameter int LOGN = 8
);
    logic            start;
    logic            mode;
    logic            in_valid;
    logic            in_ready;
    logic            ld_we;
    logic [LOGN-3:0] ld_addr;
    logic            bf_rd_en;
    logic [LOGN-1:0] bf_a0, bf_a1, bf_a2, bf_a3;
    logic [LOGN-1:0] tw_idx0, tw_idx1;
    logic            bf_mode;
    logic            bf_wr_en;
    logic [LOGN-1:0] wb_a0, wb_a1, wb_a2, wb_a3;
    logic            out_rd_en;
    logic [LOGN-3:0] out_idx;
    logic            out_valid;
    logic            in_done;
    logic            cal_done;
    logic            done;

    modport master (
        output start, mode, in_valid,
        input  in_ready, ld_we, ld_addr, bf_rd_en,
        input  bf_a0, bf_a1, bf_a2, bf_a3, tw_idx0, tw_idx1, bf_mode,
        input  bf_wr_en, wb_a0, wb_a1, wb_a2, wb_a3,
        input  out_rd_en, out_idx, out_valid, in_done, cal_done, done
    );

    modport slave (
        input  start, mode, in_valid,
        output in_ready, ld_we, ld_addr, bf_rd_en,
        output bf_a0, bf_a1, bf_a2, bf_a3, tw_idx0, tw_idx1, bf_mode,
        output bf_wr_en, wb_a0, wb_a1, wb_a2, wb_a3,
        output out_rd_en, out_idx, out_valid, in_done, cal_done, done
    );
endinterface

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched
//   Control sequencer for the NTT/INTT butterfly datapath. After a start
//   request it runs LOAD (N/4 four-coefficient beats), LOGN butterfly stages
//   on two parallel butterfly units (each stage N/4 issue cycles plus a
//   PIPE_LAT drain), then UNLOAD (N/4 read beats). It generates all RAM
//   addresses, strobes, twiddle indices and status flags; no data is held.
//
//   Ports:
//     clk      system clock, rising edge
//     rst      synchronous active-high reset
//     bus      ntt_stage_sched_if.slave (all handshake/address/flag signals)
//     cyc_cnt  32-bit busy-cycle counter, present only when the macro
//              NTT_STAGE_SCHED_PERF_EN is defined. It clears at start
//              acceptance, counts every LOAD/CALC/BARRIER/UNLOAD cycle and
//              freezes in DONE. With a gap-free load this reads
//              N/4 + LOGN*(N/4+PIPE_LAT) + N/4 = 672 at defaults: DONE is
//              entered right after the last unload beat, so the out_valid
//              cycle is not counted.

// Per-unit butterfly address / twiddle generator for butterfly index b of
// stage s. lo/hi are the two coefficient addresses, tw the twiddle index.
module ntt_bf_addr #(
    parameter int LOGN = 8,
    parameter int SW   = 3
) (
    input  logic [LOGN-2:0] b,
    input  logic [SW-1:0]   s,
    input  logic            mode,
    output logic [LOGN-1:0] lo,
    output logic [LOGN-1:0] hi,
    output logic [LOGN-1:0] tw
);
    localparam logic [LOGN-1:0] ONE  = LOGN'(1);
    localparam logic [LOGN-1:0] HALF = ONE << (LOGN - 1);
    localparam logic [SW-1:0]   SMAX = SW'(LOGN - 1);

    logic [SW-1:0]   l;      // log2 of the butterfly span h
    logic [SW:0]     l1;
    logic [LOGN-1:0] bw;
    logic [LOGN-1:0] mask;
    logic [LOGN-1:0] lo_w;

    always_comb begin
        // Forward (CT) spans shrink with the stage, inverse (GS) spans grow.
        l    = mode ? s : SMAX - s;
        l1   = {1'b0, l} + 1'b1;
        bw   = {1'b0, b};
        mask = (ONE << l) - ONE;
        // Insert a zero bit at position l: group base plus offset in group.
        lo_w = ((bw >> l) << l1) | (bw & mask);
        lo   = lo_w;
        hi   = lo_w + (ONE << l);
        // N>>(s+1) is expressed as HALF>>s so it fits in LOGN bits.
        tw   = mode ? (HALF >> s) + (bw >> s) : (ONE << s) + (bw >> l);
    end
endmodule

module ntt_stage_sched #(
    parameter int N        = 256,
    parameter int LOGN     = 8,
    parameter int PIPE_LAT = 4
) (
    input  logic                clk,
    input  logic                rst,
    ntt_stage_sched_if.slave    bus
`ifdef NTT_STAGE_SCHED_PERF_EN
    ,
    output logic [31:0]         cyc_cnt
`endif
);
    localparam int NU = 2;                      // parallel butterfly units
    localparam int SW = $clog2(LOGN);
    localparam int KW = LOGN - 2;
    localparam int BW = $clog2(PIPE_LAT + 1);

    localparam logic [KW-1:0] K_LAST = KW'(N / 4 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);
    localparam logic [BW-1:0] B_LAST = BW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_BAR,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t          state, state_nxt;

    logic            armed;
    logic            mode_q;
    logic [KW-1:0]   ld_cnt;
    logic [KW-1:0]   k_cnt;
    logic [SW-1:0]   s_cnt;
    logic [BW-1:0]   bar_cnt;
    logic [KW-1:0]   u_cnt;
    logic            in_done, cal_done, done;
    logic            out_valid;

    logic            in_ready, bf_rd_en, out_rd_en;
    logic            accept, ld_we;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        bf_rd_en  = 1'b0;
        out_rd_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && armed) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid && ld_cnt == K_LAST) state_nxt = S_CALC;
            end
            S_CALC: begin
                bf_rd_en = 1'b1;
                if (k_cnt == K_LAST) state_nxt = S_BAR;
            end
            S_BAR: begin
                if (bar_cnt == B_LAST)
                    state_nxt = (s_cnt == S_LAST) ? S_UNLOAD : S_CALC;
            end
            S_UNLOAD: begin
                out_rd_en = 1'b1;
                if (u_cnt == K_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                // Wait for done to be visible before releasing to IDLE.
                if (done && !bus.start) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept = (state == S_IDLE) && bus.start && armed;
    assign ld_we  = bus.in_valid & in_ready;

    // ------------------------------------------------------------------
    // Counters, flags, arming
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            armed     <= 1'b1;
            mode_q    <= 1'b0;
            ld_cnt    <= '0;
            k_cnt     <= '0;
            s_cnt     <= '0;
            bar_cnt   <= '0;
            u_cnt     <= '0;
            in_done   <= 1'b0;
            cal_done  <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // One-cycle RAM read latency on the unload path.
            out_valid <= out_rd_en;
            case (state)
                S_IDLE: begin
                    if (!bus.start) armed <= 1'b1;
                    if (accept) begin
                        armed    <= 1'b0;
                        mode_q   <= bus.mode;
                        in_done  <= 1'b0;
                        cal_done <= 1'b0;
                        done     <= 1'b0;
                        ld_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (ld_we) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        if (ld_cnt == K_LAST) begin
                            in_done <= 1'b1;
                            s_cnt   <= '0;
                            k_cnt   <= '0;
                        end
                    end
                end
                S_CALC: begin
                    k_cnt   <= k_cnt + 1'b1;
                    bar_cnt <= '0;
                end
                S_BAR: begin
                    bar_cnt <= bar_cnt + 1'b1;
                    if (bar_cnt == B_LAST) begin
                        bar_cnt <= '0;
                        k_cnt   <= '0;
                        if (s_cnt == S_LAST) begin
                            cal_done <= 1'b1;
                            u_cnt    <= '0;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                S_UNLOAD: begin
                    u_cnt <= u_cnt + 1'b1;
                end
                S_DONE: begin
                    done <= 1'b1;
                    // Leaving DONE requires start low, which is the low
                    // cycle that re-arms a back-to-back run.
                    if (done && !bus.start) armed <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef NTT_STAGE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            cyc_cnt <= '0;
        else if (accept)
            cyc_cnt <= '0;
        else if (state != S_IDLE && state != S_DONE)
            cyc_cnt <= cyc_cnt + 32'd1;
    end
`endif

    // ------------------------------------------------------------------
    // Butterfly address generation: unit u handles butterfly 2k+u
    // ------------------------------------------------------------------
    logic [NU-1:0][LOGN-1:0] lo, hi, tw;
    logic [3:0][LOGN-1:0]    iss_a;
    logic [NU-1:0][LOGN-1:0] iss_tw;

    for (genvar u = 0; u < NU; u++) begin : g_unit
        ntt_bf_addr #(
            .LOGN (LOGN),
            .SW   (SW)
        ) u_addr (
            .b    ({k_cnt, 1'(u)}),
            .s    (s_cnt),
            .mode (mode_q),
            .lo   (lo[u]),
            .hi   (hi[u]),
            .tw   (tw[u])
        );
    end

    // Addresses are forced to zero outside CALC so idle outputs stay quiet.
    assign iss_a  = bf_rd_en ? {hi[1], lo[1], hi[0], lo[0]} : '0;
    assign iss_tw = bf_rd_en ? tw : '0;

    // ------------------------------------------------------------------
    // Write-back delay line, free-running regardless of state
    // ------------------------------------------------------------------
    logic [PIPE_LAT:1]                  vld_pipe;
    logic [PIPE_LAT:1][3:0][LOGN-1:0]   a_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a_pipe   <= '0;
        end else begin
            vld_pipe[1] <= bf_rd_en;
            a_pipe[1]   <= iss_a;
            for (int i = 2; i <= PIPE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready;
    assign bus.ld_we     = ld_we;
    assign bus.ld_addr   = in_ready ? ld_cnt : '0;
    assign bus.bf_rd_en  = bf_rd_en;
    assign bus.bf_a0     = iss_a[0];
    assign bus.bf_a1     = iss_a[1];
    assign bus.bf_a2     = iss_a[2];
    assign bus.bf_a3     = iss_a[3];
    assign bus.tw_idx0   = iss_tw[0];
    assign bus.tw_idx1   = iss_tw[1];
    assign bus.bf_mode   = mode_q;
    assign bus.bf_wr_en  = vld_pipe[PIPE_LAT];
    assign bus.wb_a0     = a_pipe[PIPE_LAT][0];
    assign bus.wb_a1     = a_pipe[PIPE_LAT][1];
    assign bus.wb_a2     = a_pipe[PIPE_LAT][2];
    assign bus.wb_a3     = a_pipe[PIPE_LAT][3];
    assign bus.out_rd_en = out_rd_en;
    assign bus.out_idx   = out_rd_en ? u_cnt : '0;
    assign bus.out_valid = out_valid;
    assign bus.in_done   = in_done;
    assign bus.cal_done  = cal_done;
    assign bus.done      = done;
endmodule

// File: tb/tb_ntt_stage_sched.sv
// tb_ntt_stage_sched
//   Randomized self-checking bench for ntt_stage_sched. Expected butterfly
//   addresses come from group/offset arithmetic (b/h, b%h); phase timing
//   comes from the cycle budget of each phase. Build with
//   NTT_STAGE_SCHED_PERF_EN defined to also check cyc_cnt.
module tb_ntt_stage_sched;
    localparam int N        = 256;
    localparam int LOGN     = 8;
    localparam int PIPE_LAT = 4;
    localparam int NB       = N / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntt_stage_sched_if #(.LOGN(LOGN)) bus ();

`ifdef NTT_STAGE_SCHED_PERF_EN
    logic [31:0] cyc_cnt;
`endif

    ntt_stage_sched #(
        .N        (N),
        .LOGN     (LOGN),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef NTT_STAGE_SCHED_PERF_EN
        ,
        .cyc_cnt (cyc_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int exp_cyc = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [127:0] all_out;
    always_comb all_out = 128'({bus.in_ready, bus.ld_we, bus.ld_addr, bus.bf_rd_en,
                                bus.bf_a0, bus.bf_a1, bus.bf_a2, bus.bf_a3,
                                bus.tw_idx0, bus.tw_idx1, bus.bf_mode, bus.bf_wr_en,
                                bus.wb_a0, bus.wb_a1, bus.wb_a2, bus.wb_a3,
                                bus.out_rd_en, bus.out_idx, bus.out_valid,
                                bus.in_done, bus.cal_done, bus.done});

    // Reference butterfly: span h, group = b/h, offset = b%h.
    function automatic void ref_bf(input int m, input int s, input int b,
                                   output int lo, output int hi, output int tw);
        int h;
        h  = (m == 0) ? (N >> (s + 1)) : (1 << s);
        lo = (b / h) * 2 * h + (b % h);
        hi = lo + h;
        tw = (m == 0) ? ((1 << s) + b / h) : (N / (2 * h) + b / h);
    endfunction

    // Write-back scoreboard: an issue must reappear PIPE_LAT cycles later.
    logic [32:0] wbq[$];

    task automatic wb_step(input logic [32:0] iss);
        logic [32:0] e;
        wbq.push_back(iss);
        e = wbq.pop_front();
        chk("wb", 128'({bus.bf_wr_en,
                        e[32] ? {bus.wb_a0, bus.wb_a1, bus.wb_a2, bus.wb_a3} : 32'd0}),
            128'(e));
    endtask

    // One transaction. vpat: 0 continuous, 1 toggling, 2 random in_valid.
    task automatic run(input int m, input int vpat, input bit abort);
        int beats, lcyc;
        int lo0, hi0, tw0, lo1, hi1, tw1;
        logic v;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.mode     = m[0];
        bus.in_valid = 1'b0;
        #1;
        chk("idle_rdy", 128'(bus.in_ready), 128'(0));

        beats = 0;
        lcyc  = 0;
        while (beats < NB && lcyc < 2000) begin
            @(negedge clk);
            case (vpat)
                0:       v = 1'b1;
                1:       v = (lcyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.mode     = 1'($urandom_range(0, 1));
            #1;
            if (lcyc == 0)
                chk("accept", 128'({bus.in_ready, bus.in_done, bus.cal_done, bus.done}),
                    128'(4'b1000));
            chk("ld", 128'({bus.ld_we, bus.in_ready, bus.bf_rd_en, v ? bus.ld_addr : 6'd0}),
                128'({v, 1'b1, 1'b0, v ? 6'(beats) : 6'd0}));
            if (v) beats++;
            lcyc++;
        end
        chk("ld_beats", 128'(beats), 128'(NB));
        if (beats < NB) return;

        wbq = {};
        repeat (PIPE_LAT) wbq.push_back('0);
        for (int s = 0; s < LOGN; s++) begin
            for (int k = 0; k < NB; k++) begin
                @(negedge clk);
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.mode     = 1'($urandom_range(0, 1));
                #1;
                if (s == 0 && k == 0)
                    chk("in_done", 128'({bus.in_done, bus.cal_done}), 128'(2'b10));
                ref_bf(m, s, 2 * k,     lo0, hi0, tw0);
                ref_bf(m, s, 2 * k + 1, lo1, hi1, tw1);
                chk("bf", 128'({bus.bf_rd_en, bus.bf_mode, bus.bf_a0, bus.bf_a1, bus.bf_a2,
                                bus.bf_a3, bus.tw_idx0, bus.tw_idx1, bus.ld_we}),
                    128'({1'b1, m[0], LOGN'(lo0), LOGN'(hi0), LOGN'(lo1), LOGN'(hi1),
                          LOGN'(tw0), LOGN'(tw1), 1'b0}));
                wb_step({1'b1, LOGN'(lo0), LOGN'(hi0), LOGN'(lo1), LOGN'(hi1)});
                if (abort && s == 3 && k == 10) begin
                    rst          = 1'b1;
                    bus.start    = 1'b0;
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    #1;
                    chk("rst_zero", all_out, 128'(0));
                    repeat (PIPE_LAT + 1) begin
                        @(negedge clk);
                        #1;
                        chk("rst_quiet", 128'({bus.bf_wr_en, bus.in_ready, bus.bf_rd_en}),
                            128'(0));
                    end
                    return;
                end
            end
            for (int p = 0; p < PIPE_LAT; p++) begin
                @(negedge clk);
                #1;
                chk("barrier", 128'({bus.bf_rd_en, bus.cal_done}), 128'(0));
                wb_step('0);
            end
        end

        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            #1;
            chk("unload", 128'({bus.out_rd_en, bus.out_idx, bus.out_valid, bus.cal_done, bus.done}),
                128'({1'b1, 6'(i), i > 0, 1'b1, 1'b0}));
            wb_step('0);
        end
        @(negedge clk);
        #1;
        chk("last_vld", 128'({bus.out_rd_en, bus.out_valid, bus.done}), 128'(3'b010));
        @(negedge clk);
        #1;
        chk("done", 128'({bus.done, bus.in_done, bus.cal_done, bus.out_valid}), 128'(4'b1110));
        exp_cyc = lcyc + LOGN * (NB + PIPE_LAT) + NB;
`ifdef NTT_STAGE_SCHED_PERF_EN
        chk("cyc_cnt", 128'(cyc_cnt), 128'(exp_cyc));
`endif
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset", all_out, 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Forward, gap-free load; start held high through DONE.
        run(0, 0, 1'b0);
        repeat (8) begin
            @(negedge clk);
            #1;
            chk("hold", 128'({bus.done, bus.in_ready, bus.bf_rd_en, bus.in_done}), 128'(4'b1001));
`ifdef NTT_STAGE_SCHED_PERF_EN
            chk("cyc_frozen", 128'(cyc_cnt), 128'(exp_cyc));
`endif
        end
        // One low cycle re-arms; the next run must clear the flags.
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("drop", 128'(bus.done), 128'(1));

        // Inverse, toggling in_valid.
        run(1, 1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);

        // Random mode and load gaps, reset mid-CALC.
        run(int'($urandom_range(0, 1)), 2, 1'b1);

        // Full random run after the reset.
        run(int'($urandom_range(0, 1)), 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
